// File: rtl/i2s_pkg.sv
// Shared types and default constants for the I2S codec power-up sequencer.
package i2s_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLK_WAIT = 3'd1,
    SETTLE   = 3'd2,
    SYNC     = 3'd3,
    UNMUTE   = 3'd4,
    RUN      = 3'd5,
    FAULT    = 3'd6
  } seq_state_t;

  localparam int unsigned DEF_RESET_CYCLES    = 1024;
  localparam int unsigned DEF_SETTLE_CYCLES   = 4194304;
  localparam int unsigned DEF_UNMUTE_FRAMES   = 16;
  localparam int unsigned DEF_WATCHDOG_CYCLES = 512;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that can hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_lrclk_edge.sv
// LRCLK edge detector: one register stage, cleared while the clock generator is held off.
module i2s_lrclk_edge (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic lrclk_i,
  output logic rise_o,
  output logic any_o
);

  logic lrclk_q;

  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      lrclk_q <= 1'b0;
    end else begin
      lrclk_q <= lrclk_i;
    end
  end

  assign rise_o = lrclk_i & ~lrclk_q;
  assign any_o  = lrclk_i ^ lrclk_q;

endmodule

// File: rtl/i2s_codec_sequencer.sv
// Power-up / run-time sequencer for the PCM1808 ADC and soft-mute DAC on the shared I2S bus.
// Define I2S_SEQ_WATCHDOG_EN to build the LRCLK-loss watchdog and the FAULT state.
//
// state    | meaning
// IDLE     | clocks off, DAC muted, waiting for enable
// CLK_WAIT | clocks running, ADC reset interval
// SETTLE   | ADC output-valid interval
// SYNC     | waiting for the first LRCLK rising edge
// UNMUTE   | discarding frames with the DAC muted
// RUN      | DAC playing, per-frame strobes issued
// FAULT    | LRCLK lost, clocks off until enable drops
module i2s_codec_sequencer
  import i2s_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned UNMUTE_FRAMES   = DEF_UNMUTE_FRAMES,
  parameter int unsigned WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       enable_i,
  input  logic       lrclk_i,
  output logic       clk_en_o,
  output logic       dac_xsmt_o,
  output logic       frame_start_o,
  output logic       running_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int unsigned TMR_W = cnt_width(max_u(RESET_CYCLES, SETTLE_CYCLES));
  localparam int unsigned FRM_W = $clog2(UNMUTE_FRAMES + 1);

  localparam logic [TMR_W-1:0] RESET_LAST  = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [FRM_W-1:0] FRAME_LAST  = FRM_W'(UNMUTE_FRAMES - 1);

  seq_state_t       state;
  seq_state_t       state_next;
  logic [TMR_W-1:0] tmr;
  logic [FRM_W-1:0] frm;
  logic             rise;
  logic             any_edge;
  logic             wd_expire;

  logic             clk_en_d;
  logic             xsmt_d;
  logic             frame_start_d;
  logic             running_d;

  i2s_lrclk_edge u_edge (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .clr_i   (~clk_en_o),
    .lrclk_i (lrclk_i),
    .rise_o  (rise),
    .any_o   (any_edge)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (enable_i) state_next = CLK_WAIT;
      CLK_WAIT: if (tmr == RESET_LAST) state_next = SETTLE;
      SETTLE:   if (tmr == SETTLE_LAST) state_next = SYNC;
      SYNC:     if (rise) state_next = UNMUTE;
      UNMUTE:   if (rise && (frm == FRAME_LAST)) state_next = RUN;
      RUN:      state_next = RUN;
      FAULT:    state_next = FAULT;
      default:  state_next = IDLE;
    endcase
    if (wd_expire) state_next = FAULT;
    // Dropping enable overrides everything, including a watchdog expiry.
    if (!enable_i) state_next = IDLE;
  end

  // ---------------------------------------------------------------- output decode
  always_comb begin
    clk_en_d      = 1'b0;
    xsmt_d        = 1'b0;
    frame_start_d = 1'b0;
    running_d     = 1'b0;
    case (state_next)
      CLK_WAIT, SETTLE, SYNC, UNMUTE: clk_en_d = 1'b1;
      RUN: begin
        clk_en_d      = 1'b1;
        xsmt_d        = 1'b1;
        running_d     = 1'b1;
        // The edge that enters RUN is still seen in UNMUTE, so it never strobes.
        frame_start_d = (state == RUN) && rise;
      end
      default: clk_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      clk_en_o      <= 1'b0;
      dac_xsmt_o    <= 1'b0;
      frame_start_o <= 1'b0;
      running_o     <= 1'b0;
    end else begin
      clk_en_o      <= clk_en_d;
      dac_xsmt_o    <= xsmt_d;
      frame_start_o <= frame_start_d;
      running_o     <= running_d;
    end
  end

  assign state_o = state;

  // ---------------------------------------------------------------- interval timer
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      tmr <= '0;
    end else if ((state_next != state) || !((state == CLK_WAIT) || (state == SETTLE))) begin
      tmr <= '0;
    end else if (tmr != '1) begin
      tmr <= tmr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- unmute frame counter
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      frm <= '0;
    end else if ((state == UNMUTE) && (state_next == UNMUTE)) begin
      if (rise) frm <= frm + 1'b1;
    end else begin
      frm <= '0;
    end
  end

`ifdef I2S_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = cnt_width(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] wd;
  logic            wd_active;

  assign wd_active = (state == SYNC) || (state == UNMUTE) || (state == RUN);
  // An edge landing on the expiry cycle keeps the FSM alive.
  assign wd_expire = wd_active && (wd == WD_LAST) && !any_edge;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wd <= '0;
    end else if (!wd_active || any_edge) begin
      wd <= '0;
    end else if (wd != WD_LAST) begin
      wd <= wd + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      fault_o <= 1'b0;
    end else begin
      fault_o <= (state_next == FAULT);
    end
  end
`else
  assign wd_expire = 1'b0;
  assign fault_o   = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_codec_sequencer.sv
// Directed bench for i2s_codec_sequencer; LRCLK (256-cycle period) is driven only while clk_en_o is high.
module tb_i2s_codec_sequencer;

  logic       clk = 1'b0;
  logic       srst;
  logic       enable;
  logic       lrclk;
  logic       clk_en_o;
  logic       dac_xsmt_o;
  logic       frame_start_o;
  logic       running_o;
  logic       fault_o;
  logic [2:0] state_o;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int phase  = 0;
  bit stall  = 1'b0;
  bit manual = 1'b0;

  logic [7:0] outs;
  assign outs = {clk_en_o, dac_xsmt_o, frame_start_o, running_o, fault_o, state_o};

  i2s_codec_sequencer #(
    .RESET_CYCLES    (8),
    .SETTLE_CYCLES   (16),
    .UNMUTE_FRAMES   (2),
    .WATCHDOG_CYCLES (300)
  ) dut (
    .clk_i         (clk),
    .srst_i        (srst),
    .enable_i      (enable),
    .lrclk_i       (lrclk),
    .clk_en_o      (clk_en_o),
    .dac_xsmt_o    (dac_xsmt_o),
    .frame_start_o (frame_start_o),
    .running_o     (running_o),
    .fault_o       (fault_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle; sample 1 ns after the edge and update the LRCLK model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!clk_en_o) begin
      phase = 0;
      lrclk = 1'b0;
    end else if (!stall && !manual) begin
      phase++;
      if (phase == 128) begin
        phase = 0;
        lrclk = ~lrclk;
      end
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From IDLE with clocks off: edges land at b+128, b+384, b+640 -> RUN at b+641.
  task automatic bringup();
    int b;
    b = cyc;
    enable = 1'b1;
    run_to(b + 1);   chk("clk_wait_entry", outs, {5'b10000, 3'd1});
    run_to(b + 8);   chk("clk_wait_last",  outs, {5'b10000, 3'd1});
    run_to(b + 9);   chk("settle_entry",   outs, {5'b10000, 3'd2});
    run_to(b + 24);  chk("settle_last",    outs, {5'b10000, 3'd2});
    run_to(b + 25);  chk("sync_entry",     outs, {5'b10000, 3'd3});
    run_to(b + 128); chk("sync_wait",      outs, {5'b10000, 3'd3});
    run_to(b + 129); chk("unmute_entry",   outs, {5'b10000, 3'd4});
    run_to(b + 640); chk("unmute_last",    outs, {5'b10000, 3'd4});
    run_to(b + 641); chk("run_entry",      outs, {5'b11010, 3'd5});
  endtask

  initial begin
    int b;
    int e;
    int pulses;
    int last;
    int bad;

    srst   = 1'b1;
    enable = 1'b0;
    lrclk  = 1'b0;
    repeat (3) step();
    chk("reset_outputs", outs, 8'h00);
    srst = 1'b0;
    step();
    chk("idle_after_reset", outs, 8'h00);

    // Nominal power-up
    b = cyc;
    chk("clk_en_before_enable", clk_en_o, 1'b0);
    bringup();
    pulses = 0;
    while (cyc < b + 896) begin
      step();
      if (frame_start_o) pulses++;
    end
    chk("no_strobe_on_entry_frame", pulses, 0);
    run_to(b + 897); chk("first_frame_start", outs, {5'b11110, 3'd5});
    run_to(b + 898); chk("frame_start_width", frame_start_o, 1'b0);

    // Steady run over 10 frames
    pulses = 0;
    bad    = 0;
    last   = b + 897;
    while (cyc < b + 898 + 2559) begin
      step();
      if (frame_start_o) begin
        pulses++;
        if (cyc - last != 256) bad++;
        last = cyc;
      end
    end
    chk("steady_pulse_count", pulses, 10);
    chk("steady_pulse_spacing", bad, 0);

    enable = 1'b0;
    step();
    chk("disable_from_run", outs, 8'h00);

    // Disable mid-SETTLE, then full restart
    b = cyc;
    enable = 1'b1;
    run_to(b + 15); chk("mid_settle", state_o, 3'd2);
    enable = 1'b0;
    run_to(b + 16); chk("settle_abort_idle", outs, 8'h00);
    bringup();

    // Synchronous reset while running
    srst = 1'b1;
    step();
    chk("srst_in_run", outs, 8'h00);
    srst   = 1'b0;
    enable = 1'b0;
    step();
    chk("idle_after_srst", outs, 8'h00);

`ifdef I2S_SEQ_WATCHDOG_EN
    // LRCLK stall in RUN: last edge at RUN entry - 1
    bringup();
    e = cyc - 1;
    stall = 1'b1;
    run_to(e + 300); chk("stall_still_run", outs, {5'b11010, 3'd5});
    run_to(e + 301); chk("stall_fault",     outs, {5'b00001, 3'd6});
    run_to(e + 351); chk("fault_held",      outs, {5'b00001, 3'd6});
    enable = 1'b0;
    step();
    chk("fault_exit_idle", outs, 8'h00);
    stall = 1'b0;

    // Edge on the expiry cycle, then enable drop on the expiry cycle
    bringup();
    e = cyc - 1;
    manual = 1'b1;
    run_to(e + 300);
    lrclk = ~lrclk;
    run_to(e + 301); chk("edge_beats_expiry", outs, {5'b11010, 3'd5});
    e = e + 300;
    run_to(e + 299); chk("pre_expiry_run", state_o, 3'd5);
    run_to(e + 300);
    enable = 1'b0;
    run_to(e + 301); chk("enable_beats_expiry", outs, 8'h00);
    manual = 1'b0;
`else
    // Without the watchdog a stall simply holds RUN
    bringup();
    stall = 1'b1;
    run_to(cyc + 1000);
    chk("stall_no_watchdog", outs, {5'b11010, 3'd5});
    stall  = 1'b0;
    enable = 1'b0;
    step();
    chk("idle_after_stall", outs, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
